// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer: owns all pipeline-stage enables and bubble controls.
// Optional perf counters are built only when PIPE_CTRL_PERF_EN is defined.
//   state  | meaning
//   RUN    | normal issue, hazard stalls handled in-cycle
//   IWAIT  | waiting on I-line fill, back end keeps draining
//   DWAIT  | waiting on D-line fill, whole pipe frozen
//   SBWAIT | store buffer full, only WB advances (with bubble)
module pipeline_ctrl #(
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hazard_stall,
    input  logic             branch_taken,
    input  logic             icache_miss,
    input  logic             icache_fill_done,
    output logic             icache_abort,
    input  logic             dcache_miss,
    input  logic             dcache_fill_done,
    input  logic             mem_is_store,
    input  logic             sb_full,
    output logic             if_en,
    output logic             id_en,
    output logic             ex_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic             bubble_id,
    output logic             bubble_ex,
    output logic             bubble_wb,
    output logic [1:0]       state,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_cyc,
    output logic [CNT_W-1:0] imiss_cyc,
    output logic [CNT_W-1:0] dmiss_cyc
);
    typedef enum logic [1:0] {RUN = 2'd0, IWAIT = 2'd1, DWAIT = 2'd2, SBWAIT = 2'd3} state_t;

    localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_t           state_q, state_d;
    logic             imiss_pend_q, imiss_pend_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             timeout_err_q, timeout_err_d;

    always_comb begin
        state_d      = state_q;
        imiss_pend_d = imiss_pend_q;
        if_en        = 1'b0;
        id_en        = 1'b0;
        ex_en        = 1'b0;
        mem_en       = 1'b0;
        wb_en        = 1'b0;
        bubble_id    = 1'b0;
        bubble_ex    = 1'b0;
        bubble_wb    = 1'b0;
        icache_abort = 1'b0;
        if (reset) begin
            bubble_id    = 1'b1;
            bubble_ex    = 1'b1;
            state_d      = RUN;
            imiss_pend_d = 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (dcache_miss) begin
                        state_d = DWAIT;
                    end else if (mem_is_store && sb_full) begin
                        wb_en     = 1'b1;
                        bubble_wb = 1'b1;
                        state_d   = SBWAIT;
                    end else if (branch_taken) begin
                        {if_en, id_en, ex_en, mem_en, wb_en} = 5'b11111;
                        bubble_id = 1'b1;
                        bubble_ex = 1'b1;
                    end else if (icache_miss) begin
                        {id_en, ex_en, mem_en, wb_en} = 4'b1111;
                        bubble_id = 1'b1;
                        state_d   = IWAIT;
                    end else if (hazard_stall) begin
                        {ex_en, mem_en, wb_en} = 3'b111;
                        bubble_ex = 1'b1;
                    end else begin
                        {if_en, id_en, ex_en, mem_en, wb_en} = 5'b11111;
                    end
                end
                IWAIT: begin
                    if (dcache_miss) begin
                        state_d      = DWAIT;
                        imiss_pend_d = 1'b1;
                    end else if (branch_taken) begin
                        // redirect makes the outstanding fetch useless
                        {if_en, id_en, ex_en, mem_en, wb_en} = 5'b11111;
                        bubble_id    = 1'b1;
                        bubble_ex    = 1'b1;
                        icache_abort = 1'b1;
                        state_d      = RUN;
                    end else begin
                        {ex_en, mem_en, wb_en} = 3'b111;
                        id_en     = !hazard_stall;
                        bubble_id = 1'b1;
                        bubble_ex = hazard_stall;
                        if (icache_fill_done) state_d = RUN;
                    end
                end
                DWAIT: begin
                    imiss_pend_d = imiss_pend_q && !icache_fill_done;
                    if (dcache_fill_done) begin
                        state_d      = (imiss_pend_q && !icache_fill_done) ? IWAIT : RUN;
                        imiss_pend_d = 1'b0;
                    end
                end
                default: begin
                    wb_en     = 1'b1;
                    bubble_wb = 1'b1;
                    if (!sb_full) state_d = RUN;
                end
            endcase
        end
    end

    // down-counter reloads on any state change; terminal count flags the error
    always_comb begin
        timeout_err_d = timeout_err_q;
        if (state_d != state_q || state_q == RUN) begin
            tmo_d = TMO_W'(TIMEOUT);
        end else begin
            tmo_d = (tmo_q != '0) ? tmo_q - 1'b1 : tmo_q;
            if (tmo_q == TMO_W'(1)) timeout_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            imiss_pend_q  <= 1'b0;
            tmo_q         <= TMO_W'(TIMEOUT);
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            imiss_pend_q  <= imiss_pend_d;
            tmo_q         <= tmo_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign state       = state_q;
    assign timeout_err = timeout_err_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cyc_q, imiss_cyc_q, dmiss_cyc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cyc_q <= '0;
            imiss_cyc_q <= '0;
            dmiss_cyc_q <= '0;
        end else begin
            if (!if_en)            stall_cyc_q <= stall_cyc_q + 1'b1;
            if (state_q == IWAIT)  imiss_cyc_q <= imiss_cyc_q + 1'b1;
            if (state_q == DWAIT)  dmiss_cyc_q <= dmiss_cyc_q + 1'b1;
        end
    end

    assign stall_cyc = stall_cyc_q;
    assign imiss_cyc = imiss_cyc_q;
    assign dmiss_cyc = dmiss_cyc_q;
`else
    assign stall_cyc = '0;
    assign imiss_cyc = '0;
    assign dmiss_cyc = '0;
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed scenarios then random traffic.
module tb_pipeline_ctrl;
    localparam int TMO = 8;
    localparam int CW  = 32;
`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    localparam int R = 256, HZ = 128, BR = 64, IM = 32, IFD = 16, DM = 8, DFD = 4, ST = 2, SBF = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, hazard_stall, branch_taken, icache_miss, icache_fill_done;
    logic dcache_miss, dcache_fill_done, mem_is_store, sb_full;
    logic icache_abort, if_en, id_en, ex_en, mem_en, wb_en;
    logic bubble_id, bubble_ex, bubble_wb, timeout_err;
    logic [1:0] state;
    logic [CW-1:0] stall_cyc, imiss_cyc, dmiss_cyc;

    pipeline_ctrl #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .hazard_stall(hazard_stall), .branch_taken(branch_taken),
        .icache_miss(icache_miss), .icache_fill_done(icache_fill_done), .icache_abort(icache_abort),
        .dcache_miss(dcache_miss), .dcache_fill_done(dcache_fill_done), .mem_is_store(mem_is_store),
        .sb_full(sb_full), .if_en(if_en), .id_en(id_en), .ex_en(ex_en), .mem_en(mem_en), .wb_en(wb_en),
        .bubble_id(bubble_id), .bubble_ex(bubble_ex), .bubble_wb(bubble_wb), .state(state),
        .timeout_err(timeout_err), .stall_cyc(stall_cyc), .imiss_cyc(imiss_cyc), .dmiss_cyc(dmiss_cyc)
    );

    typedef struct {
        logic [4:0]    en;
        logic [2:0]    bub;
        logic          abort;
        logic [1:0]    st;
        logic          err;
        logic [CW-1:0] sc, ic, dc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    // reference state: mode 0 run, 1 fetch-wait, 2 data-wait, 3 store-drain
    int          m_mode = 0;
    bit          m_ifetch_owed = 1'b0;
    int          m_wait_len = 0;
    bit          m_err = 1'b0;
    bit [CW-1:0] m_stall = '0, m_imiss = '0, m_dmiss = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    task automatic step(input int v, input bit check = 1'b1);
        bit rst, hz, br, im, ifd, dm, dfd, stv, sbf;
        exp_t e;
        int nxt;
        bit owed;
        {rst, hz, br, im, ifd, dm, dfd, stv, sbf} = 9'(v);
        @(posedge clk);
        #1;
        reset = rst; hazard_stall = hz; branch_taken = br; icache_miss = im;
        icache_fill_done = ifd; dcache_miss = dm; dcache_fill_done = dfd;
        mem_is_store = stv; sb_full = sbf;
        if (!check) return;
        e.en = 5'b00000; e.bub = 3'b000; e.abort = 1'b0;
        e.st = 2'(m_mode); e.err = m_err;
        e.sc = PERF ? m_stall : '0;
        e.ic = PERF ? m_imiss : '0;
        e.dc = PERF ? m_dmiss : '0;
        nxt = m_mode;
        owed = m_ifetch_owed;
        if (rst) begin
            e.bub = 3'b110;
        end else if (m_mode == 0) begin
            if (dm) nxt = 2;
            else if (stv && sbf) begin e.en = 5'b00001; e.bub = 3'b001; nxt = 3; end
            else if (br) begin e.en = 5'b11111; e.bub = 3'b110; end
            else if (im) begin e.en = 5'b01111; e.bub = 3'b100; nxt = 1; end
            else if (hz) begin e.en = 5'b00111; e.bub = 3'b010; end
            else e.en = 5'b11111;
        end else if (m_mode == 1) begin
            if (dm) begin nxt = 2; owed = 1'b1; end
            else if (br) begin e.en = 5'b11111; e.bub = 3'b110; e.abort = 1'b1; nxt = 0; end
            else begin
                e.en  = hz ? 5'b00111 : 5'b01111;
                e.bub = hz ? 3'b110 : 3'b100;
                if (ifd) nxt = 0;
            end
        end else if (m_mode == 2) begin
            if (ifd) owed = 1'b0;
            if (dfd) begin nxt = owed ? 1 : 0; owed = 1'b0; end
        end else begin
            e.en = 5'b00001; e.bub = 3'b001;
            if (!sbf) nxt = 0;
        end
        q.push_back(e);
        if (rst) begin
            m_mode = 0; m_ifetch_owed = 1'b0; m_wait_len = 0; m_err = 1'b0;
            m_stall = '0; m_imiss = '0; m_dmiss = '0;
        end else begin
            if (!e.en[4]) m_stall++;
            if (m_mode == 1) m_imiss++;
            if (m_mode == 2) m_dmiss++;
            if (nxt != m_mode || m_mode == 0) m_wait_len = 0;
            else begin
                m_wait_len++;
                if (m_wait_len == TMO) m_err = 1'b1;
            end
            m_mode = nxt;
            m_ifetch_owed = owed;
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("enables", 64'({if_en, id_en, ex_en, mem_en, wb_en}), 64'(e.en));
            chk("bubbles", 64'({bubble_id, bubble_ex, bubble_wb}), 64'(e.bub));
            chk("icache_abort", 64'(icache_abort), 64'(e.abort));
            chk("state", 64'(state), 64'(e.st));
            chk("timeout_err", 64'(timeout_err), 64'(e.err));
            chk("stall_cyc", 64'(stall_cyc), 64'(e.sc));
            chk("imiss_cyc", 64'(imiss_cyc), 64'(e.ic));
            chk("dmiss_cyc", 64'(dmiss_cyc), 64'(e.dc));
        end
    end

    initial begin
        reset = 1'b1; hazard_stall = 1'b0; branch_taken = 1'b0; icache_miss = 1'b0;
        icache_fill_done = 1'b0; dcache_miss = 1'b0; dcache_fill_done = 1'b0;
        mem_is_store = 1'b0; sb_full = 1'b0;
        step(R, 1'b0);
        step(R); step(R);
        repeat (3) step(0);
        step(HZ); step(0);
        step(IM); repeat (4) step(0); step(IFD); step(0); step(0);
        step(IM); step(DM); step(0); step(0); step(DFD); step(0); step(IFD); step(0);
        step(IM); step(DM); step(IFD); step(DFD); step(0); step(0);
        step(IM); step(0); step(BR); step(0);
        step(IM); step(HZ); step(IFD); step(0);
        step(BR | IM); step(0);
        repeat (3) step(ST | SBF); step(ST); step(0);
        step(DM); repeat (10) step(0); step(R); step(0); step(0);
        repeat (3000) begin
            int v;
            v = 0;
            if ($urandom_range(63) == 0) v |= R;
            if ($urandom_range(3) == 0)  v |= HZ;
            if ($urandom_range(7) == 0)  v |= BR;
            if ($urandom_range(5) == 0)  v |= IM;
            if ($urandom_range(9) == 0)  v |= DM;
            if ($urandom_range(2) == 0)  v |= ST;
            if ($urandom_range(2) == 0)  v |= SBF;
            if ((m_mode == 1 || (m_mode == 2 && m_ifetch_owed)) && $urandom_range(4) == 0) v |= IFD;
            if (m_mode == 2 && $urandom_range(4) == 0) v |= DFD;
            if (m_mode == 1 && (v & IFD) != 0) v &= ~(BR | DM);
            step(v);
        end
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 64'(q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage multi-cycle core with caches and store buffer. It merges the load-use/MOVRM hazard stall, I-cache and D-cache miss waits, store-buffer-full back-pressure and taken-branch redirects. From these it drives per-stage pipeline-register enables and bubble/flush controls. Sits beside the hazard unit in the core top and owns every pipeline enable.

## Interface
- `TIMEOUT`, default 1023: wait-state cycle limit before `timeout_err` is set.
- `CNT_W`, default 32: width of the performance counters.
- `clk` in 1: core clock.
- `reset` in 1: synchronous, active-high.
- `hazard_stall` in 1: hazard-unit stall request for the ID instruction.
- `branch_taken` in 1: taken branch/jump resolved in EX.
- `icache_miss` in 1: I-cache lookup missed this cycle (level, valid in RUN).
- `icache_fill_done` in 1: 1-cycle pulse, I-line filled.
- `icache_abort` out 1: 1-cycle pulse, cancel outstanding I-fill.
- `dcache_miss` in 1: MEM-stage access missed.
- `dcache_fill_done` in 1: 1-cycle pulse, D-line filled.
- `mem_is_store` in 1: MEM stage holds a store.
- `sb_full` in 1: store buffer has no free slot.
- `if_en`, `id_en`, `ex_en`, `mem_en`, `wb_en` out 1 each: pipeline register/PC load enables.
- `bubble_id` out 1: load NOP into IF/ID.
- `bubble_ex` out 1: load NOP into ID/EX.
- `bubble_wb` out 1: load NOP into MEM/WB.
- `state` out 2: RUN=0, IWAIT=1, DWAIT=2, SBWAIT=3.
- `timeout_err` out 1: sticky, cleared only by reset.
- `stall_cyc`, `imiss_cyc`, `dmiss_cyc` out CNT_W each: performance counters.

## Operation
- Outputs are combinational from `state` and the inputs. State, `imiss_pend`, the timeout counter and the performance counters are registered.
- RUN decisions, highest priority first:
  1. `dcache_miss`: all enables 0 → DWAIT.
  2. `mem_is_store&&sb_full`: IF..MEM enables 0, `wb_en`=1, `bubble_wb`=1 → SBWAIT.
  3. `branch_taken`: all enables 1, `bubble_id`=`bubble_ex`=1. A concurrent `icache_miss` is ignored (wrong path).
  4. `icache_miss`: `if_en`=0, `bubble_id`=1, ID..WB run → IWAIT.
  5. `hazard_stall`: `if_en`=`id_en`=0, `bubble_ex`=1, EX..WB run.
  6. Otherwise all enables 1 and no bubbles.
- IWAIT:
  - `if_en`=0, `bubble_id`=1; `hazard_stall` still applies to ID/EX as in RUN.
  - `icache_fill_done` → RUN.
  - `branch_taken`: `icache_abort`=1, same flushes as RUN, `if_en`=1 → RUN.
  - `dcache_miss` → DWAIT with `imiss_pend`=1; all enables 0 that cycle.
- DWAIT:
  - All enables 0.
  - An `icache_fill_done` seen here clears `imiss_pend`.
  - `dcache_fill_done` → IWAIT if `imiss_pend` is still 1 (checked after this cycle's clear), else RUN.
  - Enables stay 0 in the done cycle.
- SBWAIT:
  - Same outputs as RUN rule 2.
  - `!sb_full` → RUN; enables stay frozen in that cycle.
- Timeout: the counter clears on every state change and in RUN, and increments in each wait state. When it reaches `TIMEOUT`, `timeout_err` is set and stays set; the FSM keeps waiting.
- Reset: `state`=RUN, `imiss_pend`=0, counters 0, `timeout_err`=0. While `reset`=1, all enables are 0, `bubble_id`=`bubble_ex`=1, `bubble_wb`=0 and `icache_abort`=0. Reset in any wait state returns to RUN the next cycle; any pending fill is dropped with no abort pulse.

## Timing
- The state transition takes effect at the next `clk` edge after the triggering input.
- The pipeline resumes on the cycle after the fill/drain pulse (DWAIT/SBWAIT) or on the fill cycle's next edge (IWAIT). Minimum miss penalty is 2 cycles.
- `icache_abort` is high for exactly 1 cycle.
- Hazard stall has zero latency: it is combinational into the same-cycle enables.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - `stall_cyc` counts cycles with `if_en`=0 and `reset`=0.
  - `imiss_cyc` counts cycles in IWAIT.
  - `dmiss_cyc` counts cycles in DWAIT.
  - Counters wrap modulo 2^CNT_W.
- Undefined: the three counter ports are tied to 0 and no counter flops are built. The ports still exist.

## Test plan
- Hazard: RUN, `hazard_stall`=1 for 1 cycle → that cycle `if_en`=`id_en`=0, `bubble_ex`=1, `ex_en`=1; `stall_cyc` +1.
- I-miss: `icache_miss`=1 at cycle 10, `icache_fill_done` at cycle 15 → `state`=1 for cycles 11–15, RUN at 16, `imiss_cyc`=5.
- D-miss over I-miss: IWAIT, `dcache_miss`=1, no I-fill before `dcache_fill_done` → DWAIT, then IWAIT; with I-fill during DWAIT → DWAIT, then RUN.
- Branch abort: IWAIT + `branch_taken` → one-cycle `icache_abort`, `bubble_id`=`bubble_ex`=1, `if_en`=1, `state`=0 next cycle.
- Store buffer: `mem_is_store`=`sb_full`=1 for 3 cycles → IF..MEM frozen, `bubble_wb`=1, `state`=3, RUN one cycle after `sb_full` falls.
- Timeout/reset: `TIMEOUT`=8, DWAIT with no fill → `timeout_err`=1 after 8 DWAIT cycles; `reset` pulse → `state`=0, `timeout_err`=0, counters 0.
